bus_slave_responder: RTL

BUS_SLAVE_RESPONDER -- requirements
Module: bus_slave_responder

---
 rtl/bus_pkg.sv | 16 +
 rtl/bus_slave_responder_if.sv | 32 +++
 rtl/slave_mem.sv | 23 ++
 rtl/bus_slave_responder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus slave responder: FSM state encoding and
// the bit positions inside the two-bit instruction field.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_DATA = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam int INSTR_VALID_BIT = 1;
  localparam int INSTR_READ_BIT  = 0;

endpackage

// File: rtl/bus_slave_responder_if.sv
// Command and beat-handshake bundle between a bus master and one slave responder.
interface bus_slave_responder_if #(
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12
);

  logic [1:0]           slave_select;
  logic [1:0]           instruction;
  logic [ADDR_LEN-1:0]  address;
  logic [BURST_LEN-1:0] burst_num;
  logic [DATA_LEN-1:0]  wr_data;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [DATA_LEN-1:0]  rd_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic                 ready;
  logic                 tx_done;
  logic                 rx_done;

  modport master (
    output slave_select, instruction, address, burst_num, wr_data, wr_valid, rd_ready,
    input  wr_ready, rd_data, rd_valid, ready, tx_done, rx_done
  );

  modport slave (
    input  slave_select, instruction, address, burst_num, wr_data, wr_valid, rd_ready,
    output wr_ready, rd_data, rd_valid, ready, tx_done, rx_done
  );

endinterface

// File: rtl/slave_mem.sv
// Single-port synchronous RAM, DATA_LEN x 2^MEM_ADDR_LEN, one-cycle read latency.
module slave_mem #(
  parameter int DATA_LEN     = 8,
  parameter int MEM_ADDR_LEN = 11
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic                    re,
  input  logic [MEM_ADDR_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0]     wdata,
  output logic [DATA_LEN-1:0]     rdata
);

  logic [DATA_LEN-1:0] mem [2**MEM_ADDR_LEN];

  // NOTE: neither the array nor the read register is reset: RAM macros have no
  // reset, and contents must survive a reset of the responder.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_slave_responder.sv
// Bus slave responder: accepts addressed read/write bursts into a local RAM.
// Define SLAVE_BURST_EN to honour burst_num; otherwise every command is one beat.
module bus_slave_responder
  import bus_pkg::*;
#(
  parameter logic [1:0] SLAVE_ID     = 2'd0,
  parameter int         ADDR_LEN     = 12,
  parameter int         DATA_LEN     = 8,
  parameter int         BURST_LEN    = 12,
  parameter int         MEM_ADDR_LEN = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_slave_responder_if.slave bus
);

  state_t                  state, state_next;
  logic [MEM_ADDR_LEN-1:0] addr;
  logic [BURST_LEN-1:0]    beats_left;   // beats still to go after the current one
  logic [BURST_LEN-1:0]    first_left;
  logic                    is_read;
  logic                    cmd_hit;
  logic                    last_beat;
  logic                    mem_we;
  logic                    mem_re;
  logic [DATA_LEN-1:0]     mem_q;

  assign cmd_hit   = bus.instruction[INSTR_VALID_BIT] && (bus.slave_select == SLAVE_ID);
  assign last_beat = (beats_left == '0);

`ifdef SLAVE_BURST_EN
  // burst_num of 0 still means one beat, so only non-zero counts shed a beat.
  assign first_left = (bus.burst_num == '0) ? '0 : bus.burst_num - BURST_LEN'(1);
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.address[ADDR_LEN-1:MEM_ADDR_LEN];
`else
  assign first_left = '0;
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{bus.address[ADDR_LEN-1:MEM_ADDR_LEN], bus.burst_num};
`endif

  // NOTE: clocked blocks use non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cmd_hit) state_next = bus.instruction[INSTR_READ_BIT] ? ST_READ_REQ : ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.wr_valid && last_beat) state_next = ST_DONE;
      end
      ST_READ_REQ:  state_next = ST_READ_DATA;
      ST_READ_DATA: begin
        if (bus.rd_ready) state_next = last_beat ? ST_DONE : ST_READ_REQ;
      end
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ready    = 1'b0;
    bus.wr_ready = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    bus.tx_done  = 1'b0;
    bus.rx_done  = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    case (state)
      ST_IDLE:  bus.ready = 1'b1;
      ST_WRITE: begin
        bus.wr_ready = 1'b1;
        mem_we       = bus.wr_valid;
      end
      ST_READ_REQ: mem_re = 1'b1;
      ST_READ_DATA: begin
        // The RAM output register only changes on a read request, so rd_data
        // holds steady for as long as the master stalls.
        bus.rd_valid = 1'b1;
        bus.rd_data  = mem_q;
      end
      ST_DONE: begin
        bus.tx_done = ~is_read;
        bus.rx_done = is_read;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      beats_left <= '0;
      is_read    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_hit) begin
            addr       <= bus.address[MEM_ADDR_LEN-1:0];
            beats_left <= first_left;
            is_read    <= bus.instruction[INSTR_READ_BIT];
          end
        end
        ST_WRITE: begin
          if (bus.wr_valid) begin
            addr <= addr + MEM_ADDR_LEN'(1);
            if (!last_beat) beats_left <= beats_left - BURST_LEN'(1);
          end
        end
        ST_READ_DATA: begin
          if (bus.rd_ready) begin
            addr <= addr + MEM_ADDR_LEN'(1);
            if (!last_beat) beats_left <= beats_left - BURST_LEN'(1);
          end
        end
        default: ;
      endcase
    end
  end

  slave_mem #(
    .DATA_LEN    (DATA_LEN),
    .MEM_ADDR_LEN(MEM_ADDR_LEN)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (addr),
    .wdata(bus.wr_data),
    .rdata(mem_q)
  );

endmodule
